// File: rtl/sprite_ram_loader.sv
// Sprite RAM loader: writes a sprite into RAM in raster order, either from a
// valid/ready pixel stream or as a solid KEY_COLOR fill.
//
// state | meaning
// IDLE  | waiting for start (stream load) or fill
// LOAD  | accepting stream pixels, one write per accepted pixel
// FILL  | writing KEY_COLOR, one pixel per cycle
// DONE  | final write issued; completion pulse follows
module sprite_ram_loader #(
    parameter int            CD        = 12,
    parameter int            ADDR      = 10,
    parameter int            H_SIZE    = 16,
    parameter int            V_SIZE    = 16,
    parameter logic [CD-1:0] KEY_COLOR = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            fill,
    input  logic            abort,
    input  logic            s_valid,
    input  logic [CD-1:0]   s_data,
    output logic            s_ready,
    output logic            we,
    output logic [ADDR-1:0] addr_w,
    output logic [CD-1:0]   pixel_out,
    output logic            busy,
    output logic            done,
    output logic [ADDR:0]   pix_cnt
);

    localparam int AW2 = ADDR / 2;
    localparam logic [AW2-1:0] COL_LAST = AW2'(H_SIZE - 1);
    localparam logic [AW2-1:0] ROW_LAST = AW2'(V_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW2-1:0]  row_q, row_d;
    logic [AW2-1:0]  col_q, col_d;
    logic            we_q, we_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [CD-1:0]   pix_q, pix_d;
    logic [ADDR:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            wr;
    logic [CD-1:0]   wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            pix_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            pix_q   <= pix_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        pix_d   = pix_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wr      = 1'b0;
        wdata   = KEY_COLOR;

        case (state_q)
            IDLE: begin
                if (start || fill) begin
                    state_d = start ? LOAD : FILL;
                    row_d   = '0;
                    col_d   = '0;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (s_valid) begin
                    wr    = 1'b1;
                    wdata = s_data;
                end
            end
            FILL: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    wr = 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Columns beyond H_SIZE-1 are skipped so only the visible sprite area is written.
        if (wr) begin
            we_d   = 1'b1;
            addr_d = ADDR'({row_q, col_q});
            pix_d  = wdata;
            cnt_d  = cnt_q + (ADDR+1)'(1);
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    state_d = DONE;
                end else begin
                    row_d = row_q + AW2'(1);
                end
            end else begin
                col_d = col_q + AW2'(1);
            end
        end
    end

    assign s_ready   = (state_q == LOAD) && !abort;
    assign busy      = (state_q != IDLE);
    assign we        = we_q;
    assign addr_w    = addr_q;
    assign pixel_out = pix_q;
    assign pix_cnt   = cnt_q;
    assign done      = done_q;

endmodule
